// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the sine generator's frequency word from a
// start to a stop frequency, holding each point for a settle and a dwell interval.
module sine_sweep_ctrl #(
  parameter int unsigned C_CLK_FRQ = 100_000_000,
  parameter int unsigned C_SETTLE  = 256,
  parameter int unsigned C_DWELL_W = 24
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          frq_start,
  input  logic [15:0]          frq_stop,
  input  logic [15:0]          frq_step,
  input  logic [C_DWELL_W-1:0] dwell,
  output logic [15:0]          frq,
  output logic                 busy,
  output logic                 settled,
  output logic [15:0]          point,
  output logic                 done
);

  localparam int unsigned SCNT_W = (C_SETTLE > 1) ? $clog2(C_SETTLE) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(C_SETTLE - 1);
  // Clock frequency is informational only.
  localparam int unsigned unused_clk_frq = C_CLK_FRQ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t                 state_q,     state_d;
  logic [15:0]            frq_q,       frq_d;
  logic [15:0]            stop_q,      stop_d;
  logic [15:0]            step_q,      step_d;
  logic [C_DWELL_W-1:0]   dwell_lim_q, dwell_lim_d;
  logic                   up_q,        up_d;
  logic [SCNT_W-1:0]      scnt_q,      scnt_d;
  logic [C_DWELL_W-1:0]   dcnt_q,      dcnt_d;
  logic [15:0]            point_q,     point_d;
  logic                   busy_q,      busy_d;
  logic                   settled_q,   settled_d;
  logic                   done_q,      done_d;

  // Candidate next point, widened to 17 bits so wrap past 0xFFFF or below 0 is visible.
  logic [16:0] frq_sum;
  logic [16:0] frq_dif;
  logic [15:0] frq_nxt;
  logic        last_pt;

  assign frq_sum = {1'b0, frq_q} + {1'b0, step_q};
  assign frq_dif = {1'b0, frq_q} - {1'b0, step_q};
  assign last_pt = (frq_q == stop_q) || (step_q == 16'd0);

  always_comb begin
    frq_nxt = stop_q;
    if (up_q) begin
      if (frq_sum <= {1'b0, stop_q}) frq_nxt = frq_sum[15:0];
    end else begin
      if (!frq_dif[16] && (frq_dif[15:0] >= stop_q)) frq_nxt = frq_dif[15:0];
    end
  end

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    frq_d       = frq_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_lim_d = dwell_lim_q;
    up_d        = up_q;
    scnt_d      = scnt_q;
    dcnt_d      = dcnt_q;
    point_d     = point_q;
    busy_d      = busy_q;
    settled_d   = settled_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SETTLE;
          frq_d       = frq_start;
          stop_d      = frq_stop;
          step_d      = frq_step;
          dwell_lim_d = (dwell == '0) ? '0 : dwell - C_DWELL_W'(1);
          up_d        = (frq_stop >= frq_start);
          scnt_d      = '0;
          dcnt_d      = '0;
          point_d     = 16'd0;
          busy_d      = 1'b1;
          settled_d   = 1'b0;
        end
      end

      S_SETTLE: begin
        if (scnt_q == SETTLE_LAST) begin
          state_d   = S_DWELL;
          settled_d = 1'b1;
          dcnt_d    = '0;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end

      S_DWELL: begin
        if (dcnt_q == dwell_lim_q) begin
          settled_d = 1'b0;
          if (last_pt) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETTLE;
            frq_d   = frq_nxt;
            point_d = point_q + 16'd1;
            scnt_d  = '0;
          end
        end else begin
          dcnt_d = dcnt_q + C_DWELL_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a coincident start in IDLE, and silences the generator.
    if (abort) begin
      state_d   = S_IDLE;
      frq_d     = 16'd0;
      busy_d    = 1'b0;
      settled_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      frq_q       <= 16'd0;
      stop_q      <= 16'd0;
      step_q      <= 16'd0;
      dwell_lim_q <= '0;
      up_q        <= 1'b0;
      scnt_q      <= '0;
      dcnt_q      <= '0;
      point_q     <= 16'd0;
      busy_q      <= 1'b0;
      settled_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frq_q       <= frq_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_lim_q <= dwell_lim_d;
      up_q        <= up_d;
      scnt_q      <= scnt_d;
      dcnt_q      <= dcnt_d;
      point_q     <= point_d;
      busy_q      <= busy_d;
      settled_q   <= settled_d;
      done_q      <= done_d;
    end
  end

  assign frq     = frq_q;
  assign busy    = busy_q;
  assign settled = settled_q;
  assign point   = point_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Self-checking bench for sine_sweep_ctrl: per-cycle output traces derived from
// the sweep rules (point list, settle/dwell lengths) are compared against the DUT.
module tb_sine_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int DW     = 24;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   frq_start = '0;
  logic [15:0]   frq_stop = '0;
  logic [15:0]   frq_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [15:0]   frq;
  logic          busy;
  logic          settled;
  logic [15:0]   point;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] frq;
    logic [15:0] point;
    logic        busy;
    logic        settled;
    logic        done;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  sine_sweep_ctrl #(
    .C_CLK_FRQ(100_000_000),
    .C_SETTLE (SETTLE),
    .C_DWELL_W(DW)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .start    (start),
    .abort    (abort),
    .frq_start(frq_start),
    .frq_stop (frq_stop),
    .frq_step (frq_step),
    .dwell    (dwell),
    .frq      (frq),
    .busy     (busy),
    .settled  (settled),
    .point    (point),
    .done     (done)
  );

  function automatic obs_t sample();
    obs_t o;
    o.frq     = frq;
    o.point   = point;
    o.busy    = busy;
    o.settled = settled;
    o.done    = done;
    return o;
  endfunction

  // Expected outputs for cycles k+1, k+2, ... after start is accepted at edge k,
  // ending with the done cycle and one idle cycle after it.
  task automatic build_trace(input int fs, input int fe, input int st, input int dw);
    int   f;
    int   idx;
    int   dwe;
    obs_t o;
    f   = fs;
    idx = 0;
    dwe = (dw == 0) ? 1 : dw;
    exp_q.delete();
    forever begin
      for (int c = 0; c < SETTLE + dwe; c++) begin
        o.frq = 16'(f); o.point = 16'(idx); o.busy = 1'b1;
        o.settled = (c >= SETTLE); o.done = 1'b0;
        exp_q.push_back(o);
      end
      if (f == fe || st == 0) break;
      if (fe >= fs) f = (f + st > fe) ? fe : f + st;
      else          f = (f - st < fe) ? fe : f - st;
      idx++;
    end
    o.frq = 16'(f); o.point = 16'(idx); o.busy = 1'b0; o.settled = 1'b0; o.done = 1'b1;
    exp_q.push_back(o);
    o.done = 1'b0;
    exp_q.push_back(o);
  endtask

  // Called at a negedge; start is seen by the next rising edge.
  task automatic launch(input int fs, input int fe, input int st, input int dw);
    frq_start = 16'(fs);
    frq_stop  = 16'(fe);
    frq_step  = 16'(st);
    dwell     = DW'(dw);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({frq, point, busy, settled, done} !== 35'd0) begin
      bad++;
      $display("FAIL reset_state got frq=%0d point=%0d busy=%0b settled=%0b done=%0b want all 0",
               frq, point, busy, settled, done);
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
  endtask

  // Up sweep 100..130 step 10, dwell 4; inputs are scrambled and start re-pulsed while busy.
  task automatic test_up_sweep();
    obs_t got;
    build_trace(100, 130, 10, 4);
    launch(100, 130, 10, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = sample();
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL up_sweep cycle=%0d got %h want %h", i + 1, got, exp_q[i]);
      end
      if (i == 1) begin
        frq_start = 16'd7; frq_stop = 16'd9000; frq_step = 16'd1; dwell = DW'(50); start = 1'b1;
      end
      if (i == 2) start = 1'b0;
      if (i < exp_q.size() - 1) @(negedge clk);
    end
  endtask

  task automatic test_down_clamp();
    obs_t got;
    int   dw;
    int   dones;
    dw    = int'($urandom_range(0, 3));
    dones = 0;
    build_trace(1000, 975, 10, dw);
    launch(1000, 975, 10, dw);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = sample();
      if (done === 1'b1) dones++;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL down_clamp cycle=%0d got %h want %h", i + 1, got, exp_q[i]);
      end
      if (i < exp_q.size() - 1) @(negedge clk);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL down_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_overflow_clamp();
    obs_t got;
    build_trace(65530, 65535, 100, 1);
    launch(65530, 65535, 100, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = sample();
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL overflow_clamp cycle=%0d got %h want %h", i + 1, got, exp_q[i]);
      end
      if (i < exp_q.size() - 1) @(negedge clk);
    end
  endtask

  task automatic test_single_point();
    obs_t got;
    build_trace(500, 900, 0, 0);
    launch(500, 900, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = sample();
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL single_point cycle=%0d got %h want %h", i + 1, got, exp_q[i]);
      end
      if (i < exp_q.size() - 1) @(negedge clk);
    end
  endtask

  // Abort in the dwell of point 2, then start+abort together in IDLE.
  task automatic test_abort();
    obs_t got;
    int   abort_idx;
    abort_idx = 2 * (SETTLE + 4) + SETTLE + 1;
    build_trace(200, 300, 10, 4);
    launch(200, 300, 10, 4);
    for (int i = 0; i <= abort_idx; i++) begin
      got = sample();
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL abort_run cycle=%0d got %h want %h", i + 1, got, exp_q[i]);
      end
      if (i == 1) start = 1'b1;
      if (i == 2) start = 1'b0;
      if (i < abort_idx) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({frq, busy, settled, done} !== 19'd0) begin
      bad++;
      $display("FAIL abort_effect got frq=%0d busy=%0b settled=%0b done=%0b want 0/0/0/0",
               frq, busy, settled, done);
    end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL abort_no_done got busy=%0b done=%0b want 0/0", busy, done);
    end
    frq_start = 16'd42; frq_stop = 16'd50; frq_step = 16'd1; dwell = DW'(1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total++;
    if ({frq, busy} !== 17'd0) begin
      bad++;
      $display("FAIL start_abort_same got frq=%0d busy=%0b want 0/0", frq, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    obs_t got;
    launch(3000, 3100, 25, 2);
    #3;
    rstb = 1'b0;
    #1;
    total++;
    if ({frq, point, busy, settled, done} !== 35'd0) begin
      bad++;
      $display("FAIL async_reset got frq=%0d point=%0d busy=%0b settled=%0b done=%0b want all 0",
               frq, point, busy, settled, done);
    end
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    build_trace(3000, 3100, 25, 2);
    launch(3000, 3100, 25, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      got = sample();
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL after_reset cycle=%0d got %h want %h", i + 1, got, exp_q[i]);
      end
      if (i < exp_q.size() - 1) @(negedge clk);
    end
  endtask

  // Random sweeps launched back to back: each start is driven in the idle cycle after done.
  task automatic test_back_to_back();
    obs_t got;
    int   fs, fe, st, dw, span;
    for (int n = 0; n < 10; n++) begin
      fs   = int'($urandom_range(0, 65535));
      span = int'($urandom_range(0, 300));
      if ($urandom_range(0, 1) == 1) fe = (fs + span > 65535) ? 65535 : fs + span;
      else                           fe = (fs - span < 0) ? 0 : fs - span;
      st = int'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0) st = int'($urandom_range(0, 65535));
      dw = int'($urandom_range(0, 3));
      build_trace(fs, fe, st, dw);
      launch(fs, fe, st, dw);
      for (int i = 0; i < exp_q.size(); i++) begin
        got = sample();
        total++;
        if (got !== exp_q[i]) begin
          bad++;
          $display("FAIL random_sweep run=%0d cycle=%0d got %h want %h", n, i + 1, got, exp_q[i]);
        end
        if (i == 1) begin
          frq_start = 16'($urandom); frq_stop = 16'($urandom); frq_step = 16'($urandom);
          dwell = DW'($urandom_range(0, 9)); start = 1'b1;
        end
        if (i == 2) start = 1'b0;
        if (i < exp_q.size() - 1) @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_down_clamp();
    test_overflow_clamp();
    test_single_point();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
